// File: rtl/ram_bridge.sv
// ram_bridge: bridges the decoder's single-request RAM port onto an 8-bit handshaked external
// RAM bus. Each 32-bit access becomes a sequence of byte transactions; read data is assembled
// little-endian. Each byte has an ack timeout, and a one-entry pending slot holds a request
// that arrives while the bridge is busy.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   ram_in  (mem_in_type) request: mem_valid, mem_addr, mem_wdata, mem_wstrb (0 = read)
//   ram_out (mem_out_type) response: mem_rdata, mem_error, mem_ready (one-cycle pulse)
//   ext_valid/ext_write/ext_addr/ext_wdata  byte transaction request towards the RAM
//   ext_rdata/ext_ack     byte completion from the RAM
//   overrun               sticky: a request was dropped because the slot was full

package ram_bridge_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;
endpackage

module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int unsigned addr_width = 20,
  parameter int unsigned timeout    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  mem_in_type            ram_in,
  output mem_out_type           ram_out,
  output logic                  ext_valid,
  output logic                  ext_write,
  output logic [addr_width-1:0] ext_addr,
  output logic [7:0]            ext_wdata,
  input  logic [7:0]            ext_rdata,
  input  logic                  ext_ack,
  output logic                  overrun
);

  typedef enum logic [1:0] {StIdle, StByte, StDone} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wstrb_q;
  logic [15:0] wait_q;

  logic        slot_valid_q;
  logic [31:0] slot_addr_q;
  logic [31:0] slot_wdata_q;
  logic [3:0]  slot_wstrb_q;

  // Lowest set strobe; a read (strb == 0) starts at lane 0.
  function automatic logic [1:0] first_lane(input logic [3:0] strb);
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (strb[i]) first_lane = 2'(i);
    end
  endfunction

  // Returns {found, lane}: next lane above idx to issue (every lane for reads).
  function automatic logic [2:0] next_of(input logic [1:0] idx, input logic [3:0] strb);
    next_of = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(idx) && (strb == 4'b0000 || strb[i])) next_of = {1'b1, 2'(i)};
    end
  endfunction

  logic        take_slot;
  logic        acc_go;
  logic        acc_err;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic [1:0]  acc_lane;
  logic        is_read;
  logic        next_found;
  logic [1:0]  next_lane;
  logic [31:0] rdata_merged;
  logic        timed_out;
  logic        capture;
  logic        drop;

  always_comb begin
    // The pending slot has priority over a new request whenever a transaction can start.
    take_slot = slot_valid_q && (state_q == StIdle || state_q == StDone);
    acc_go    = take_slot || (state_q == StIdle && ram_in.mem_valid);
    acc_addr  = take_slot ? slot_addr_q  : ram_in.mem_addr;
    acc_wdata = take_slot ? slot_wdata_q : ram_in.mem_wdata;
    acc_wstrb = take_slot ? slot_wstrb_q : ram_in.mem_wstrb;
    acc_err   = (acc_addr >> addr_width) != 32'd0;
    acc_lane  = first_lane(acc_wstrb);

    is_read                 = (wstrb_q == 4'b0000);
    {next_found, next_lane} = next_of(idx_q, wstrb_q);
    rdata_merged            = rdata_q;
    rdata_merged[8*idx_q +: 8] = ext_rdata;
    timed_out = !ext_ack && (wait_q == 16'(timeout));

    // A request that is not started directly goes into the slot if it is (or becomes) free.
    capture = ram_in.mem_valid && (state_q != StIdle || take_slot) &&
              (!slot_valid_q || take_slot);
    drop    = ram_in.mem_valid && slot_valid_q && !take_slot && state_q != StIdle;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      wait_q       <= '0;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_wstrb_q <= '0;
      ram_out      <= '0;
      ext_valid    <= 1'b0;
      ext_write    <= 1'b0;
      ext_addr     <= '0;
      ext_wdata    <= '0;
      overrun      <= 1'b0;
    end else begin
      ram_out <= '0;

      if (capture) begin
        slot_valid_q <= 1'b1;
        slot_addr_q  <= ram_in.mem_addr;
        slot_wdata_q <= ram_in.mem_wdata;
        slot_wstrb_q <= ram_in.mem_wstrb;
      end else if (take_slot) begin
        slot_valid_q <= 1'b0;
      end
      if (drop) overrun <= 1'b1;

      if (acc_go) begin
        wdata_q <= acc_wdata;
        wstrb_q <= acc_wstrb;
        rdata_q <= '0;
        wait_q  <= '0;
        idx_q   <= acc_lane;
        if (acc_err) begin
          state_q           <= StDone;
          ext_valid         <= 1'b0;
          ram_out.mem_ready <= 1'b1;
          ram_out.mem_error <= 1'b1;
        end else begin
          state_q   <= StByte;
          ext_valid <= 1'b1;
          ext_write <= (acc_wstrb != 4'b0000);
          // Low two request address bits are replaced by the lane index.
          ext_addr  <= (acc_addr[addr_width-1:0] & ~addr_width'(3)) | addr_width'(acc_lane);
          ext_wdata <= acc_wdata[8*acc_lane +: 8];
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StIdle;
          end
          StDone: begin
            state_q <= StIdle;
          end
          StByte: begin
            if (ext_ack) begin
              if (is_read) rdata_q <= rdata_merged;
              if (next_found) begin
                idx_q     <= next_lane;
                ext_addr  <= {ext_addr[addr_width-1:2], next_lane};
                ext_wdata <= wdata_q[8*next_lane +: 8];
                wait_q    <= '0;
              end else begin
                state_q           <= StDone;
                ext_valid         <= 1'b0;
                ram_out.mem_ready <= 1'b1;
                ram_out.mem_rdata <= is_read ? rdata_merged : 32'd0;
              end
            end else if (timed_out) begin
              // Remaining lanes are abandoned.
              state_q           <= StDone;
              ext_valid         <= 1'b0;
              ram_out.mem_ready <= 1'b1;
              ram_out.mem_error <= 1'b1;
            end else begin
              wait_q <= wait_q + 16'd1;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_bridge.sv
// Self-checking bench for ram_bridge: a reference model pushes expected byte transactions and
// responses into queues when a request is driven; a monitor pops and compares them as the DUT
// produces bus traffic and responses.
module tb_ram_bridge;
  import ram_bridge_pkg::*;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  mem_in_type    ram_in = '0;
  mem_out_type   ram_out;
  logic          ext_valid;
  logic          ext_write;
  logic [AW-1:0] ext_addr;
  logic [7:0]    ext_wdata;
  logic [7:0]    ext_rdata;
  logic          ext_ack;
  logic          overrun;

  ram_bridge #(.addr_width(AW), .timeout(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ram_in    (ram_in),
    .ram_out   (ram_out),
    .ext_valid (ext_valid),
    .ext_write (ext_write),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // External RAM and the model's own copy of it.
  logic [7:0] ext_mem [4096];
  logic [7:0] ref_mem [4096];
  logic [2:0] stall_lane = 3'd4;  // 4 = every lane acks

  assign ext_rdata = ext_mem[ext_addr[11:0]];
  assign ext_ack   = ext_valid && ({1'b0, ext_addr[1:0]} != stall_lane);

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [7:0]    data;
  } byte_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } resp_t;

  byte_t byte_q[$];
  resp_t resp_q[$];

  // Reference model: expected bytes, response and latency of one request once accepted.
  task automatic expect_req(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int extra);
    resp_t         r;
    byte_t         b;
    logic [AW-1:0] base;
    int            nbytes;
    logic          tmo;
    r.rdata = '0;
    r.err   = 1'b0;
    nbytes  = 0;
    tmo     = 1'b0;
    if ((addr >> AW) != 0) begin
      r.err = 1'b1;
    end else begin
      base = addr[AW-1:0] & ~AW'(3);
      for (int lane = 0; lane < 4; lane++) begin
        if (tmo) continue;
        if (strb != 4'b0000 && !strb[lane]) continue;
        if (lane == int'(stall_lane)) begin
          tmo = 1'b1;
          continue;
        end
        b.addr = base + AW'(lane);
        b.wr   = (strb != 4'b0000);
        b.data = b.wr ? wdata[8*lane +: 8] : 8'h00;
        byte_q.push_back(b);
        nbytes++;
        if (b.wr) ref_mem[b.addr[11:0]] = b.data;
        else      r.rdata[8*lane +: 8] = ref_mem[b.addr[11:0]];
      end
      if (tmo) begin
        r.err   = 1'b1;
        r.rdata = '0;
      end
      if (strb != 4'b0000) r.rdata = '0;
    end
    r.lat = 1 + nbytes + (tmo ? int'(TO) + 1 : 0) + extra;
    r.t0  = cyc;
    resp_q.push_back(r);
  endtask

  // Drive one request for exactly one sampling edge.
  task automatic send(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      input int extra, input bit expect_it);
    if (expect_it) expect_req(addr, wdata, strb, extra);
    ram_in.mem_valid = 1'b1;
    ram_in.mem_addr  = addr;
    ram_in.mem_wdata = wdata;
    ram_in.mem_wstrb = strb;
    @(posedge clock); #1;
    ram_in = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while ((byte_q.size() != 0 || resp_q.size() != 0) && n < 200);
    check("drain_bytes", 96'(byte_q.size()), 96'd0);
    check("drain_resp", 96'(resp_q.size()), 96'd0);
    byte_q.delete();
    resp_q.delete();
  endtask

  // Monitor.
  logic          prev_valid = 1'b0;
  logic          prev_ack   = 1'b0;
  logic [AW-1:0] prev_addr;
  logic          prev_write;
  logic [7:0]    prev_wdata;

  always @(negedge clock) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (ext_valid && prev_valid && !prev_ack) begin
        check("stable_addr", 96'(ext_addr), 96'(prev_addr));
        check("stable_write", 96'(ext_write), 96'(prev_write));
        check("stable_wdata", 96'(ext_wdata), 96'(prev_wdata));
      end
      if (ext_valid && ext_ack) begin
        if (byte_q.size() == 0) begin
          check("byte_unexpected", 96'(ext_addr), 96'hFFFFFFFF);
        end else begin
          byte_t b;
          b = byte_q.pop_front();
          check("byte_addr", 96'(ext_addr), 96'(b.addr));
          check("byte_write", 96'(ext_write), 96'(b.wr));
          if (b.wr) check("byte_wdata", 96'(ext_wdata), 96'(b.data));
          if (ext_write) ext_mem[ext_addr[11:0]] = ext_wdata;
        end
      end
      if (ram_out.mem_ready) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 96'(ram_out.mem_ready), 96'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_rdata", 96'(ram_out.mem_rdata), 96'(r.rdata));
          check("resp_error", 96'(ram_out.mem_error), 96'(r.err));
          check("resp_latency", 96'(cyc - r.t0), 96'(r.lat));
        end
      end
      prev_valid <= ext_valid;
      prev_ack   <= ext_ack;
      prev_addr  <= ext_addr;
      prev_write <= ext_write;
      prev_wdata <= ext_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin
      ext_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ext_mem[12'h100] = 8'h11; ext_mem[12'h101] = 8'h22;
    ext_mem[12'h102] = 8'h33; ext_mem[12'h103] = 8'h44;
    ref_mem[12'h100] = 8'h11; ref_mem[12'h101] = 8'h22;
    ref_mem[12'h102] = 8'h33; ref_mem[12'h103] = 8'h44;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ram_out", 96'(ram_out), 96'd0);
    check("rst_ext_valid", 96'(ext_valid), 96'd0);
    check("rst_ext_bus", 96'({ext_write, ext_addr, ext_wdata}), 96'd0);
    check("rst_overrun", 96'(overrun), 96'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Reads and writes, ack tied high.
    send(32'h100, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();
    send(32'h20, 32'hAABBCCDD, 4'b1010, 0, 1'b1);
    wait_done();
    send(32'h20, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();
    send(32'h33, 32'h12345678, 4'b0001, 0, 1'b1);
    wait_done();
    send(32'h44, 32'hCAFEF00D, 4'b1111, 0, 1'b1);
    wait_done();
    send(32'h47, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();

    // Out of range: error, no external traffic.
    send(32'h0010_0000, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();
    send(32'hFFFF_FFFF, 32'h55, 4'b0001, 0, 1'b1);
    wait_done();

    // Timeout on lane 1.
    stall_lane = 3'd1;
    send(32'h100, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();
    check("tmo_ext_valid_low", 96'(ext_valid), 96'd0);
    check("tmo_ready_low", 96'(ram_out.mem_ready), 96'd0);
    stall_lane = 3'd4;
    @(posedge clock); #1;

    // Pending slot: A; B held; C dropped; D arrives on the edge leaving A's DONE.
    check("pre_overrun", 96'(overrun), 96'd0);
    send(32'h100, 32'h0, 4'b0000, 0, 1'b1);           // A
    send(32'h30, 32'h0000BEEF, 4'b0011, 4, 1'b1);     // B
    send(32'h50, 32'h0, 4'b0000, 0, 1'b0);            // C
    @(posedge clock); #1;
    @(posedge clock); #1;
    send(32'h30, 32'h0, 4'b0000, 3, 1'b1);            // D
    wait_done();
    check("overrun_set", 96'(overrun), 96'd1);

    // Reset in the middle of a read, after lane 1 completes.
    send(32'h100, 32'h0, 4'b0000, 0, 1'b1);
    n = 0;
    while (!(ext_valid && ext_addr[1:0] == 2'd2) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("reach_lane2", 96'(ext_valid && ext_addr[1:0] == 2'd2), 96'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_ext_valid", 96'(ext_valid), 96'd0);
    check("midrst_ram_out", 96'(ram_out), 96'd0);
    check("midrst_overrun", 96'(overrun), 96'd0);
    reset = 1'b0;
    byte_q.delete();
    resp_q.delete();
    @(posedge clock); #1;
    send(32'h104, 32'h0, 4'b0000, 0, 1'b1);
    wait_done();
    repeat (3) @(posedge clock);
    #1;
    check("final_idle", 96'(ext_valid), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
